// File: rtl/qif_pkg.sv
// Shared types and helpers for the time-multiplexed QIF neuron scheduler.
// Holds the voltage/current types, the sweep FSM states and the 8-bit saturator.
package qif_pkg;

    localparam int V_W = 8;

    typedef logic signed [V_W-1:0] v_t;
    typedef logic signed [V_W-1:0] i_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

    // Clamp a 16-bit intermediate into the 8-bit voltage range.
    function automatic v_t sat8(input logic signed [15:0] x);
        if (x > 16'sd127) begin
            return v_t'(8'h7f);
        end else if (x < -16'sd128) begin
            return v_t'(8'h80);
        end else begin
            return v_t'(x[7:0]);
        end
    endfunction

endpackage

// File: rtl/qif_scheduler_if.sv
// Control, current-write, readback and spike-event signals of the QIF scheduler.
// The scheduler uses the slave modport; the driving logic uses master.
interface qif_scheduler_if
    import qif_pkg::*;
#(
    parameter int IDX_W = 3
);
    logic             step_start;
    logic             cur_we;
    logic [IDX_W-1:0] cur_addr;
    i_t               cur_data;
    logic [IDX_W-1:0] rd_addr;
    v_t               rd_data;
    logic             busy;
    logic             step_done;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_id;

    modport slave (
        input  step_start, cur_we, cur_addr, cur_data, rd_addr,
        output rd_data, busy, step_done, spike_valid, spike_id
    );

    modport master (
        output step_start, cur_we, cur_addr, cur_data, rd_addr,
        input  rd_data, busy, step_done, spike_valid, spike_id
    );
endinterface

// File: rtl/qif_update.sv
// Combinational QIF membrane update for one neuron:
// fire when v >= v_th, otherwise v + i/4 + (v/8)^2 saturated to 8 bits.
module qif_update
    import qif_pkg::*;
(
    input  v_t   v,
    input  i_t   i,
    input  v_t   v_th,
    input  v_t   v_reset,
    output v_t   v_next,
    output logic fire
);
    logic signed [15:0] v16;
    logic signed [15:0] i16;
    logic signed [15:0] q16;
    logic signed [15:0] sum16;

    // Signed '/' truncates toward zero, unlike an arithmetic shift.
    always_comb begin
        v16    = {{8{v[7]}}, v};
        i16    = {{8{i[7]}}, i};
        q16    = v16 / 16'sd8;
        sum16  = v16 + (i16 / 16'sd4) + (q16 * q16);
        fire   = (v >= v_th);
        v_next = fire ? v_reset : sat8(sum16);
    end
endmodule

// File: rtl/qif_scheduler.sv
// Sweeps all neurons through one shared QIF update unit per step_start pulse,
// storing per-neuron voltage and pending current in register arrays.
module qif_scheduler
    import qif_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int V_TH      = 50,
    parameter int V_RESET   = -20,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic            clk,
    input  logic            reset,
    qif_scheduler_if.slave  bus
);
    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             step_done_q, step_done_d;
    logic             spike_valid_q;
    logic [IDX_W-1:0] spike_id_q;
    v_t               v_q [N_NEURONS];
    i_t               i_q [N_NEURONS];

    logic             proc;
    v_t               v_next;
    logic             fire;

    qif_update u_update (
        .v       (v_q[idx_q]),
        .i       (i_q[idx_q]),
        .v_th    (v_t'(V_TH)),
        .v_reset (v_t'(V_RESET)),
        .v_next  (v_next),
        .fire    (fire)
    );

    // The step_done cycle is still busy, so a start there is dropped.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        proc        = 1'b0;
        step_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.step_start && !step_done_q) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                proc = 1'b1;
                if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                step_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            step_done_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_q[n] <= '0;
                i_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            step_done_q   <= step_done_d;
            spike_valid_q <= proc && fire;
            if (proc && fire) begin
                spike_id_q <= idx_q;
            end
            if (proc) begin
                v_q[idx_q] <= v_next;
                i_q[idx_q] <= '0;
            end
            // Placed after the consume-clear so a same-cycle write survives.
            if (bus.cur_we) begin
                i_q[bus.cur_addr] <= bus.cur_data;
            end
        end
    end

    assign bus.rd_data     = v_q[bus.rd_addr];
    assign bus.busy        = (state_q != IDLE) || step_done_q;
    assign bus.step_done   = step_done_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.spike_id    = spike_id_q;
endmodule

// File: tb/tb_qif_scheduler.sv
// Directed bench for qif_scheduler: reset abort, integration chain, truncation,
// multi-spike timing, write/clear collision and consume-on-read.
module tb_qif_scheduler;
    import qif_pkg::*;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    qif_scheduler_if #(.IDX_W(IDX_W)) bus ();

    qif_scheduler #(
        .N_NEURONS (N),
        .V_TH      (50),
        .V_RESET   (-20),
        .IDX_W     (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    v_t   tv, ti, tth, trst, tvn;
    logic tfire;

    qif_update u_unit (
        .v       (tv),
        .i       (ti),
        .v_th    (tth),
        .v_reset (trst),
        .v_next  (tvn),
        .fire    (tfire)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        bus.cur_we   = 1'b1;
        bus.cur_addr = IDX_W'(a);
        bus.cur_data = 8'(d);
        @(negedge clk);
        bus.cur_we   = 1'b0;
    endtask

    task automatic chk_v(input string tag, input int a, input int e);
        bus.rd_addr = IDX_W'(a);
        #1;
        check(tag, bus.rd_data, e);
    endtask

    task automatic unit(input string tag, input int v, input int i,
                        input int exp_v, input int exp_f);
        tv = 8'(v);
        ti = 8'(i);
        #1;
        check({tag, " v_next"}, tvn, exp_v);
        check({tag, " fire"}, {31'd0, tfire}, exp_f);
    endtask

    // One sweep; m counts negedges after the edge that samples step_start.
    task automatic run_step(input string tag, input int coll_m, input int coll_addr,
                            input int coll_data, input bit poke,
                            input logic [7:0] exp_mask);
        int         done_m;
        logic [7:0] mask;
        done_m = -1;
        mask   = '0;
        @(negedge clk);
        bus.step_start = 1'b1;
        @(negedge clk);
        bus.step_start = 1'b0;
        for (int m = 0; m < 14; m++) begin
            if (bus.spike_valid === 1'b1) begin
                check({tag, " spike_id timing"}, bus.spike_id, m - 1);
                mask[bus.spike_id] = 1'b1;
            end
            if (bus.step_done === 1'b1 && done_m < 0) done_m = m;
            if (m == 0 || m == 9) check({tag, " busy high"}, bus.busy, 1);
            if (m == 10 || m == 13) check({tag, " busy low"}, bus.busy, 0);
            bus.step_start = poke && (m == 4 || m == 9);
            if (m == coll_m) begin
                bus.cur_we   = 1'b1;
                bus.cur_addr = IDX_W'(coll_addr);
                bus.cur_data = 8'(coll_data);
            end else begin
                bus.cur_we = 1'b0;
            end
            @(negedge clk);
        end
        bus.step_start = 1'b0;
        bus.cur_we     = 1'b0;
        check({tag, " spike mask"}, {24'd0, mask}, {24'd0, exp_mask});
        check({tag, " step_done cycle"}, done_m, 9);
    endtask

    initial begin
        bit seen_done;
        reset          = 1'b1;
        bus.step_start = 1'b0;
        bus.cur_we     = 1'b0;
        bus.cur_addr   = '0;
        bus.cur_data   = '0;
        bus.rd_addr    = '0;
        tth  = 8'sd50;
        trst = -8'sd20;
        tv   = '0;
        ti   = '0;
        #2;
        check("reset busy", bus.busy, 0);
        check("reset step_done", bus.step_done, 0);
        check("reset spike_valid", bus.spike_valid, 0);
        check("reset spike_id", bus.spike_id, 0);
        chk_v("reset V0", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Datapath corners that the sweep cannot reach from reset.
        unit("sat -128+127", -128, 127, 127, 0);
        unit("trunc -9,-3", -9, -3, -8, 0);
        unit("trunc -1,-1", -1, -1, -1, 0);
        unit("fire at 50", 50, 0, -20, 1);
        unit("below th 49", 49, 10, 87, 0);

        wr(0, 40);
        run_step("pre", -1, 0, 0, 1'b0, 8'h00);
        chk_v("pre V0", 0, 10);

        // Abort a sweep three cycles in; neuron 4's pending current must vanish.
        wr(0, 40);
        wr(4, 40);
        @(negedge clk);
        bus.step_start = 1'b1;
        @(negedge clk);
        bus.step_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort spike_valid", bus.spike_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < N; a++) chk_v("abort V", a, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.step_done === 1'b1) seen_done = 1'b1;
        end
        check("abort no step_done", {31'd0, seen_done}, 0);
        check("abort idle busy", bus.busy, 0);

        // Integration chain on neuron 0; first sweep also pokes step_start while busy.
        wr(0, 40);
        run_step("chain1", -1, 0, 0, 1'b1, 8'h00);
        chk_v("chain1 V0", 0, 10);
        chk_v("chain1 V4", 4, 0);
        wr(0, 40);
        run_step("chain2", -1, 0, 0, 1'b0, 8'h00);
        chk_v("chain2 V0", 0, 21);
        wr(0, 40);
        run_step("chain3", -1, 0, 0, 1'b0, 8'h00);
        chk_v("chain3 V0", 0, 35);
        wr(0, 40);
        run_step("chain4", -1, 0, 0, 1'b0, 8'h00);
        chk_v("chain4 V0", 0, 61);
        wr(0, 40);
        run_step("chain5", -1, 0, 0, 1'b0, 8'h01);
        chk_v("chain5 V0", 0, -20);
        run_step("chain6", -1, 0, 0, 1'b0, 8'h00);
        chk_v("chain6 V0", 0, -16);

        // Load neurons 2 and 5 to 61; neuron 6 exercises truncation in the sweep.
        wr(2, 40); wr(5, 40); wr(6, -36);
        run_step("multiA", -1, 0, 0, 1'b0, 8'h00);
        chk_v("multiA V6", 6, -9);
        chk_v("multiA V2", 2, 10);
        wr(2, 40); wr(5, 40); wr(6, -3);
        run_step("multiB", -1, 0, 0, 1'b0, 8'h00);
        chk_v("multiB V6", 6, -8);
        wr(2, 40); wr(5, 40);
        run_step("multiC", -1, 0, 0, 1'b0, 8'h00);
        wr(2, 40); wr(5, 40);
        run_step("multiD", -1, 0, 0, 1'b0, 8'h00);
        chk_v("multiD V2", 2, 61);
        chk_v("multiD V5", 5, 61);
        run_step("multiE", -1, 0, 0, 1'b0, 8'h24);
        chk_v("multiE V2", 2, -20);
        chk_v("multiE V5", 5, -20);
        chk_v("multiE V0", 0, -8);

        // Write to neuron 3 in the very cycle it is processed.
        wr(3, 8);
        run_step("collA", 3, 3, 40, 1'b0, 8'h00);
        chk_v("collA V3", 3, 2);
        run_step("collB", -1, 0, 0, 1'b0, 8'h00);
        chk_v("collB V3", 3, 12);

        wr(1, 20);
        run_step("consA", -1, 0, 0, 1'b0, 8'h00);
        chk_v("consA V1", 1, 5);
        run_step("consB", -1, 0, 0, 1'b0, 8'h00);
        chk_v("consB V1", 1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qif_scheduler.md
# qif_scheduler

Time-multiplexed controller that shares one quadratic integrate-and-fire (QIF) update datapath across `N_NEURONS` neurons. It holds each neuron's 8-bit signed membrane voltage and pending synaptic current, and sweeps all neurons once per `step_start` pulse. It emits one spike event per firing neuron and sits between the synapse/current-injection logic and the spike router.

## Interface
- `N_NEURONS`, 8: neurons served; power of two, 2..64.
- `V_TH`, 50: signed firing threshold.
- `V_RESET`, -20: signed post-spike voltage.
- `IDX_W`, $clog2(N_NEURONS): neuron index width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `step_start`  in  1  pulse; begins one sweep when idle.
- `cur_we`  in  1  write a neuron's synaptic current.
- `cur_addr`  in  IDX_W  target neuron of `cur_we`.
- `cur_data`  in  8  signed current value; overwrites, does not accumulate.
- `rd_addr`  in  IDX_W  voltage readback address.
- `rd_data`  out  8  signed V of `rd_addr`; combinational read.
- `busy`  out  1  high while a sweep is in progress.
- `step_done`  out  1  one-cycle pulse at sweep end.
- `spike_valid`  out  1  one-cycle pulse per firing neuron.
- `spike_id`  out  IDX_W  index of the firing neuron; valid with `spike_valid`.

## Operation
- Reset, asynchronous: all V := 0, all currents := 0, FSM := IDLE, `idx` := 0. Outputs `busy`, `step_done`, `spike_valid` := 0 and `spike_id` := 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `step_start` moves to RUN with `idx` := 0.
  - RUN: processes neuron `idx` each cycle. If `idx` = N_NEURONS-1, go to DONE; otherwise `idx`++.
  - DONE: `step_done` = 1 for one cycle, then go to IDLE.
- `step_start` is ignored in RUN and DONE. It is not queued.
- Per-neuron update in RUN, with v = V[idx] and i = I[idx]:
  - If v ≥ V_TH: V[idx] := V_RESET; `spike_valid` = 1 and `spike_id` = idx, both registered.
  - Else: V[idx] := sat8(v + i/4 + (v/8)*(v/8)).
  - All arithmetic is signed. `/` truncates toward zero and is not an arithmetic shift. The sum is formed in 16 bits and saturated to [-128, 127].
  - I[idx] := 0 after use (consume-on-read).
- Current writes are accepted in every state.
  - If `cur_we` targets the neuron being processed in the same RUN cycle, the update uses the old I and the written value survives: the write beats the clear.
- `rd_data` reflects V after the most recent write edge. A read of the neuron being updated returns the pre-update value during that cycle.

## Timing
- `step_start` sampled high at edge T0 (state IDLE):
  - `busy` = 1 from T0 through T0+N_NEURONS+1.
  - Neuron k is written at edge T0+k+1.
  - The spike for neuron k is visible in the cycle after edge T0+k+1.
  - `step_done` is high in the cycle after edge T0+N_NEURONS+1; `busy` is still 1 in that cycle.
- Sweep latency is N_NEURONS+1 cycles. The earliest accepted next `step_start` is the cycle after `step_done`.
- At most one spike per cycle, so spike events need no arbitration.
- Reset asserted mid-sweep aborts immediately: no `step_done`, and all state is cleared.

## Structure
- Package `qif_pkg`:
  - Width constant `V_W`=8.
  - Types `v_t`/`i_t` (logic signed [7:0]).
  - FSM enum `sched_state_t` {IDLE, RUN, DONE}.
  - `sat8` function.
- Sub-module `qif_update`: purely combinational, with inputs v, i, V_TH, V_RESET and outputs v_next, fire. The scheduler instantiates exactly one.
- Voltage and current storage are register arrays (N_NEURONS×8 each), not SRAM.

## Test plan
- Reset/idle: assert `reset` mid-sweep with N=8 → all `rd_data` = 0, `busy` = 0, no `step_done`. `step_start` ignored while `busy`.
- Integration chain, neuron 0, writing `cur_data`=40 before each step:
  - V goes 10 → 21 → 35 → 61.
  - Fifth step → spike with `spike_id`=0 and V = -20.
  - Sixth step with i=0 → V = -16.
- Truncation and saturation:
  - V=-9, i=-3 → -9 + 0 + 1 = -8 (trunc, not floor).
  - V=-128, i=127 → 159 saturates to 127.
- Multiple spikes: neurons 2 and 5 preloaded ≥ 50 → `spike_valid` pulses exactly at sweep cycles 3 and 6, with ids 2 and 5. `step_done` comes 9 cycles after `step_start`.
- Write collision: `cur_we` to neuron 3 in the cycle neuron 3 is processed → that step uses the old current and the next step uses the new value.
- Consume-on-read: two steps with a single write of i=20 to neuron 1 from V=0 → V=5, then 5 (current cleared, (5/8)^2 = 0).
